rom_scan_reader: RTL and testbench
==================================

Name: rom_scan_reader

Overview:
- Upstream controller for the case-based 8-entry x 4-field ROM.
- On a start pulse it walks every ROM address from 0 to max, drives address/read-enable/chip-enable, and captures all four 8-bit fields per address.
- It serialises the captured words onto a single valid/ready byte stream for the next stage (UART/display/checker).
- Owns the ROM's ce and read_en: the ROM is enabled only while a scan is in progress.

Parameters:
- ADDR_W, 3, ROM address width; a scan covers 2**ADDR_W addresses.
- DATA_W, 8, width of each ROM field and of out_data.
- ROM_LAT, 1, cycles from rom_addr change to valid rom_data_f*; legal range 1..7.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a scan; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until the done cycle
- done  out  1  one-cycle pulse after the final beat is accepted
- rom_addr  out  ADDR_W  ROM address
- rom_read_en  out  1  ROM read enable
- rom_ce  out  1  ROM chip enable
- rom_data_f1..rom_data_f4  in  DATA_W each  ROM field outputs
- out_data  out  DATA_W  current stream byte
- out_addr  out  ADDR_W  ROM address the byte came from
- out_field  out  2  field index: 0=F1 .. 3=F4
- out_last  out  1  high on the final beat of the scan (addr max, field 3)
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from downstream

Behaviour:
- Reset: all outputs 0. State goes to IDLE, capture registers and counters are cleared. Reset takes effect at the next edge from any state, including mid-scan or mid-beat; no done pulse is issued.
- All outputs are registered.
- States: IDLE, WAIT, EMIT, DONE.
- IDLE:
  - start=1 → rom_addr=0, rom_ce=1, rom_read_en=1, busy=1, wait counter=0, go WAIT.
  - start=0 → stay IDLE.
- WAIT:
  - Counter increments each cycle.
  - On the edge where counter reaches ROM_LAT-1, latch rom_data_f1..f4 into four capture registers, set field=0 and out_valid=1, go EMIT.
  - rom_addr is held stable throughout WAIT.
- EMIT:
  - out_data = capture[field]; out_addr = rom_addr; out_field = field.
  - A beat is accepted on an edge where out_valid && out_ready.
  - Without acceptance, out_data/out_addr/out_field/out_last/out_valid hold stable. out_valid never drops before acceptance.
  - Accepted beat with field<3 → field+1 on the next cycle; out_valid stays 1 (back-to-back beats).
  - Accepted beat with field=3 and rom_addr<max → out_valid=0, rom_addr+1, counter=0, go WAIT.
  - Accepted beat with field=3 and rom_addr=max → out_valid=0, rom_ce=0, rom_read_en=0, go DONE.
- DONE: done=1 and busy=0 for exactly one cycle, rom_addr returns to 0, go IDLE.
- start is ignored in WAIT, EMIT and DONE; a start in the DONE cycle is not queued. A new scan may begin from IDLE the cycle after DONE.
- out_last=1 only while presenting addr=max, field=3.
- rom_addr never wraps during a scan; the scan ends at max.
- Throughput with out_ready held high: ROM_LAT+4 cycles per address, 8*(ROM_LAT+4) cycles per scan plus the DONE cycle.

Test Plan:
- Full scan, ready=1, ROM_LAT=1. Bench ROM model returns field k of addr a = a*4+k. Pulse start for 1 cycle → out_data sequence 0x00..0x1F in order, 32 beats, out_last only on 0x1F. done pulses exactly once, 41 cycles after the start edge. rom_ce=rom_read_en=1 exactly while busy.
- Backpressure: ready low for 3 cycles on each beat at addr 2 → bytes 0x08..0x0B are each held stable while ready is low. No byte is lost or duplicated, and rom_addr does not advance until 0x0B is accepted.
- ROM_LAT=3 with ROM data changing only after 3 cycles (X before) → captured values are correct. The first out_valid rises 3 cycles after the start edge.
- Start while busy: pulse start again mid-scan at addr 4 → scan unaffected, still 32 beats, single done. A start in the DONE cycle is ignored; a start 2 cycles after done begins a fresh scan from addr 0.
- Reset mid-operation: assert rst during an EMIT beat at addr 5 with out_valid=1 → next cycle all outputs are 0 and state is IDLE, with no done pulse. A following start yields a complete 32-beat scan from 0x00.
- Idle behaviour: no start for 50 cycles → out_valid, rom_ce, rom_read_en, busy and done all remain 0.

Source files
------------

// File: rtl/rom_scan_reader.sv
// Scans every ROM address after a start pulse, captures the four fields of each
// address and streams them out one byte per valid/ready beat.
module rom_scan_reader #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_read_en,
    output logic              rom_ce,
    input  logic [DATA_W-1:0] rom_data_f1,
    input  logic [DATA_W-1:0] rom_data_f2,
    input  logic [DATA_W-1:0] rom_data_f3,
    input  logic [DATA_W-1:0] rom_data_f4,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [1:0]        out_field,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [2:0]        LAT_LAST = 3'(ROM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StEmit, StDone} state_t;

    state_t            state;
    logic [2:0]        wait_cnt;
    logic [DATA_W-1:0] cap [4];
    logic [1:0]        field_nxt;

    assign field_nxt = out_field + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            wait_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rom_addr    <= '0;
            rom_read_en <= 1'b0;
            rom_ce      <= 1'b0;
            out_data    <= '0;
            out_addr    <= '0;
            out_field   <= '0;
            out_last    <= 1'b0;
            out_valid   <= 1'b0;
            for (int i = 0; i < 4; i++) cap[i] <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        rom_addr    <= '0;
                        rom_ce      <= 1'b1;
                        rom_read_en <= 1'b1;
                        busy        <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= StWait;
                    end
                end
                StWait: begin
                    wait_cnt <= wait_cnt + 3'd1;
                    // ROM output has settled for the held address: capture all fields
                    if (wait_cnt == LAT_LAST) begin
                        cap[0]    <= rom_data_f1;
                        cap[1]    <= rom_data_f2;
                        cap[2]    <= rom_data_f3;
                        cap[3]    <= rom_data_f4;
                        out_data  <= rom_data_f1;
                        out_addr  <= rom_addr;
                        out_field <= 2'd0;
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= StEmit;
                    end
                end
                StEmit: begin
                    if (out_valid && out_ready) begin
                        if (out_field != 2'd3) begin
                            out_field <= field_nxt;
                            out_data  <= cap[field_nxt];
                            out_last  <= (field_nxt == 2'd3) && (rom_addr == ADDR_MAX);
                        end else if (rom_addr != ADDR_MAX) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            rom_addr  <= rom_addr + 1'b1;
                            wait_cnt  <= '0;
                            state     <= StWait;
                        end else begin
                            out_valid   <= 1'b0;
                            out_last    <= 1'b0;
                            rom_ce      <= 1'b0;
                            rom_read_en <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= StDone;
                        end
                    end
                end
                StDone: begin
                    done     <= 1'b0;
                    rom_addr <= '0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_scan_reader.sv
// Bench for rom_scan_reader: two instances (ROM latency 1 and 3) with ROM models,
// randomized backpressure and a queue-based scoreboard per instance.
module tb_rom_scan_reader;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic a_start = 1'b0, b_start = 1'b0;
    logic a_ready = 1'b1, b_ready = 1'b1;
    logic a_busy, a_done, a_rre, a_rce, a_last, a_valid;
    logic b_busy, b_done, b_rre, b_rce, b_last, b_valid;
    logic [AW-1:0] a_raddr, a_oaddr, b_raddr, b_oaddr;
    logic [DW-1:0] a_odata, b_odata;
    logic [1:0] a_ofield, b_ofield;
    logic [DW-1:0] a_f [4];
    logic [DW-1:0] b_f [4];

    rom_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT_A)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .rom_addr(a_raddr), .rom_read_en(a_rre), .rom_ce(a_rce),
        .rom_data_f1(a_f[0]), .rom_data_f2(a_f[1]), .rom_data_f3(a_f[2]),
        .rom_data_f4(a_f[3]), .out_data(a_odata), .out_addr(a_oaddr),
        .out_field(a_ofield), .out_last(a_last), .out_valid(a_valid), .out_ready(a_ready)
    );

    rom_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT_B)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .rom_addr(b_raddr), .rom_read_en(b_rre), .rom_ce(b_rce),
        .rom_data_f1(b_f[0]), .rom_data_f2(b_f[1]), .rom_data_f3(b_f[2]),
        .rom_data_f4(b_f[3]), .out_data(b_odata), .out_addr(b_oaddr),
        .out_field(b_ofield), .out_last(b_last), .out_valid(b_valid), .out_ready(b_ready)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference ROM contents and expected beat streams {last, field, addr, data}
    logic [DW-1:0] rom_tab [32];
    logic [13:0] a_q [$];
    logic [13:0] b_q [$];

    task automatic set_tab(input bit rnd);
        for (int i = 0; i < 32; i++) rom_tab[i] = rnd ? 8'($urandom) : 8'(i);
    endtask

    task automatic push_scan(input bit b);
        logic [13:0] e;
        for (int a = 0; a < 8; a++)
            for (int k = 0; k < 4; k++) begin
                e = {(a == 7 && k == 3), 2'(k), 3'(a), rom_tab[a * 4 + k]};
                if (b) b_q.push_back(e);
                else a_q.push_back(e);
            end
    endtask

    // ROM models: data is garbage until LAT cycles after the address (or enable) changes
    int a_age = 0, b_age = 0;
    logic [AW-1:0] a_prev = '0, b_prev = '0;
    logic a_pce = 1'b0, b_pce = 1'b0;

    always @(negedge clk) begin
        if (a_raddr != a_prev || !a_pce) a_age = 0;
        else a_age++;
        a_prev = a_raddr;
        a_pce  = a_rce;
        for (int k = 0; k < 4; k++)
            a_f[k] = (a_rce && a_rre && a_age >= LAT_A - 1) ?
                     rom_tab[int'(a_raddr) * 4 + k] : (8'hA5 ^ 8'(k));
        if (b_raddr != b_prev || !b_pce) b_age = 0;
        else b_age++;
        b_prev = b_raddr;
        b_pce  = b_rce;
        for (int k = 0; k < 4; k++)
            b_f[k] = (b_rce && b_rre && b_age >= LAT_B - 1) ?
                     rom_tab[int'(b_raddr) * 4 + k] : (8'h5A ^ 8'(k));
    end

    // Ready generation: 1 = always high, 2 = 3-cycle stall per beat at addr 2, 3 = random
    int rdy_mode = 1;
    bit b_rand = 1'b0;
    int lowcnt = 0;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 2 && a_valid && a_oaddr == 3'd2) begin
            if (lowcnt < 3) begin
                a_ready = 1'b0;
                lowcnt++;
            end else begin
                a_ready = 1'b1;
                lowcnt = 0;
            end
        end else if (rdy_mode == 3) a_ready = ($urandom_range(0, 3) != 0);
        else a_ready = 1'b1;
        b_ready = b_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    logic [13:0] a_pk, b_pk;
    logic [35:0] a_all, b_all;
    assign a_pk  = {a_last, a_ofield, a_oaddr, a_odata};
    assign b_pk  = {b_last, b_ofield, b_oaddr, b_odata};
    assign a_all = {a_busy, a_done, a_rce, a_rre, a_valid, a_raddr, a_pk, 8'h00};
    assign b_all = {b_busy, b_done, b_rce, b_rre, b_valid, b_raddr, b_pk, 8'h00};

    bit idle_chk = 1'b0;
    bit a_hold = 1'b0, b_hold = 1'b0;
    logic [13:0] a_held = '0, b_held = '0;
    int a_dones = 0, b_dones = 0;

    always @(negedge clk) begin
        if (rst) begin
            a_hold = 1'b0;
            b_hold = 1'b0;
        end else begin
            chk("a_ce_re_track_busy", {a_rce, a_rre}, {a_busy, a_busy});
            chk("b_ce_re_track_busy", {b_rce, b_rre}, {b_busy, b_busy});
            if (a_hold) chk("a_stall_hold", {a_valid, a_pk}, {1'b1, a_held});
            if (b_hold) chk("b_stall_hold", {b_valid, b_pk}, {1'b1, b_held});
            if (a_valid) chk("a_out_addr_eq_rom_addr", a_oaddr, a_raddr);
            if (b_valid) chk("b_out_addr_eq_rom_addr", b_oaddr, b_raddr);
            if (a_valid && a_ready) begin
                chk("a_beat_expected", a_q.size() != 0, 1'b1);
                if (a_q.size() != 0) chk("a_beat", a_pk, a_q.pop_front());
            end
            if (b_valid && b_ready) begin
                chk("b_beat_expected", b_q.size() != 0, 1'b1);
                if (b_q.size() != 0) chk("b_beat", b_pk, b_q.pop_front());
            end
            a_hold = a_valid && !a_ready;
            a_held = a_pk;
            b_hold = b_valid && !b_ready;
            b_held = b_pk;
            if (a_done) a_dones++;
            if (b_done) b_dones++;
            if (idle_chk) chk("idle_quiet", {a_valid, a_rce, a_rre, a_busy, a_done}, 5'd0);
        end
    end

    task automatic scan_start(input bit b, input bit push);
        @(posedge clk);
        #1;
        if (b) b_start = 1'b1;
        else a_start = 1'b1;
        if (push) push_scan(b);
        @(posedge clk);
        #1;
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    // Counts negedges after the start edge until done is seen (bounded)
    task automatic wait_done(input bit b, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(b ? b_done : a_done) && n < 3000);
        chk("done_seen", b ? b_done : a_done, 1'b1);
    endtask

    task automatic wait_a_addr(input logic [AW-1:0] addr);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(a_valid && a_oaddr == addr) && n < 1000);
        chk("a_reached_addr", {a_valid, a_oaddr}, {1'b1, addr});
    endtask

    initial begin
        int n;
        int dones_before;
        set_tab(1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("a_reset_outputs", a_all, 36'd0);
        chk("b_reset_outputs", b_all, 36'd0);

        // Idle: no start for 50 cycles
        idle_chk = 1'b1;
        repeat (50) @(negedge clk);
        idle_chk = 1'b0;

        // Full scan, ready high: done in cycle 8*(LAT+4)+1 after the start edge
        rdy_mode = 1;
        scan_start(1'b0, 1'b1);
        wait_done(1'b0, n);
        chk("t1_done_latency", n, 8 * (LAT_A + 4) + 1);
        chk("t1_drained", a_q.size(), 0);

        // Backpressure at addr 2 adds 3 stall cycles to each of its 4 beats
        rdy_mode = 2;
        scan_start(1'b0, 1'b1);
        wait_done(1'b0, n);
        chk("t2_done_latency", n, 8 * (LAT_A + 4) + 1 + 12);

        // Random data and random backpressure
        rdy_mode = 3;
        set_tab(1'b1);
        scan_start(1'b0, 1'b1);
        wait_done(1'b0, n);
        chk("t3_drained", a_q.size(), 0);

        // Start while busy is ignored; start in done cycle is ignored
        rdy_mode = 1;
        scan_start(1'b0, 1'b1);
        wait_a_addr(3'd4);
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        wait_done(1'b0, n);
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        @(negedge clk);
        chk("t4_done_start_ignored", {a_busy, a_rce}, 2'b00);
        scan_start(1'b0, 1'b1);
        wait_done(1'b0, n);
        chk("t4_fresh_scan_latency", n, 8 * (LAT_A + 4) + 1);

        // Reset mid-beat at addr 5
        rdy_mode = 3;
        scan_start(1'b0, 1'b1);
        wait_a_addr(3'd5);
        dones_before = a_dones;
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_reset_outputs", a_all, 36'd0);
        #1 rst = 1'b0;
        a_q.delete();
        repeat (5) @(negedge clk);
        chk("t5_no_done", a_dones, dones_before);
        chk("t5_idle_after_reset", {a_busy, a_valid}, 2'b00);
        set_tab(1'b0);
        rdy_mode = 1;
        scan_start(1'b0, 1'b1);
        wait_done(1'b0, n);
        chk("t5_rescan_latency", n, 8 * (LAT_A + 4) + 1);

        // ROM latency 3: first valid rises 3 edges after the start edge
        set_tab(1'b1);
        scan_start(1'b1, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_valid && n < 100);
        chk("b_first_valid_latency", n, LAT_B + 1);
        wait_done(1'b1, n);
        chk("b_drained", b_q.size(), 0);
        b_rand = 1'b1;
        scan_start(1'b1, 1'b1);
        wait_done(1'b1, n);

        repeat (3) @(negedge clk);
        chk("a_done_count", a_dones, 6);
        chk("b_done_count", b_dones, 2);
        chk("a_queue_empty", a_q.size(), 0);
        chk("b_queue_empty", b_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
